// File: rtl/sys_irq_ctrl_pkg.sv
// rtl/sys_irq_ctrl_pkg.sv - shared constants for the sys_irq_ctrl interrupt controller
package sys_irq_ctrl_pkg;

    localparam int NUM_SRC_DEF = 8;
    localparam int ID_W_DEF    = 5;

    localparam logic [2:0] ADDR_PENDING    = 3'd0;
    localparam logic [2:0] ADDR_ENABLE     = 3'd1;
    localparam logic [2:0] ADDR_CLAIM      = 3'd2;
    localparam logic [2:0] ADDR_EDGE_MODE  = 3'd3;
    localparam logic [2:0] ADDR_IN_SERVICE = 3'd4;

    // ID 0 is reserved for "no interrupt"; source i reports ID i+1
    localparam int ID_NONE = 0;

endpackage

// File: rtl/sys_irq_prio_enc.sv
// rtl/sys_irq_prio_enc.sv - lowest-index-first priority encoder returning index+1
module sys_irq_prio_enc
    import sys_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // Scan from the top down so the lowest set index is the last to assign
    always_comb begin
        valid = 1'b0;
        id    = ID_W'(ID_NONE);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/sys_irq_ctrl.sv
// rtl/sys_irq_ctrl.sv - Avalon-MM interrupt controller with claim/complete; SYS_IRQ_CTRL_SYNC_EN adds an input synchroniser
module sys_irq_ctrl
    import sys_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               read_n,
    input  logic               write_n,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               irq_out
);

    logic [NUM_SRC-1:0] src_s;

`ifdef SYS_IRQ_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;

    // Two-stage shift for asynchronous request lines
    always_comb begin
        sync1_d = irq_src;
        sync2_d = sync1_q;
    end

    // Synchroniser flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    logic [31:0]        readdata_q, readdata_d;
    logic               irq_out_q, irq_out_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_mode_q, edge_mode_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] hist_q, hist_d;

    logic [NUM_SRC-1:0] cand;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_id;
    logic               rd, wr;
    logic [NUM_SRC-1:0] set_vec, claim_mask, complete_mask;
    logic               unused_wdata;

    assign rd   = chipselect & ~read_n;
    assign wr   = chipselect & ~write_n;
    assign cand = pending_q & enable_q & ~in_service_q;
    assign unused_wdata = &{1'b0, writedata};

    sys_irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (cand),
        .valid (enc_valid),
        .id    (enc_id)
    );

    // Next-state: pending/in-service bookkeeping, register writes and read mux
    always_comb begin
        set_vec       = (edge_mode_q & src_s & ~hist_q)
                      | (~edge_mode_q & src_s & ~in_service_q);
        claim_mask    = '0;
        complete_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rd && (address == ADDR_CLAIM) && enc_valid && (enc_id == ID_W'(i + 1)))
                claim_mask[i] = 1'b1;
            if (wr && (address == ADDR_CLAIM) && (writedata[ID_W-1:0] == ID_W'(i + 1)))
                complete_mask[i] = 1'b1;
        end
        complete_mask = complete_mask & in_service_q;

        // A claim-clear beats a same-cycle set on the same bit
        pending_d    = (pending_q | set_vec) & ~claim_mask;
        in_service_d = (in_service_q | claim_mask) & ~complete_mask;
        hist_d       = src_s;
        irq_out_d    = |cand;

        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        if (wr && (address == ADDR_ENABLE))
            enable_d = writedata[NUM_SRC-1:0];
        if (wr && (address == ADDR_EDGE_MODE))
            edge_mode_d = writedata[NUM_SRC-1:0];

        readdata_d = 32'd0;
        if (rd) begin
            case (address)
                ADDR_PENDING:    readdata_d = 32'(pending_q);
                ADDR_ENABLE:     readdata_d = 32'(enable_q);
                ADDR_CLAIM:      readdata_d = 32'(enc_id);
                ADDR_EDGE_MODE:  readdata_d = 32'(edge_mode_q);
                ADDR_IN_SERVICE: readdata_d = 32'(in_service_q);
                default:         readdata_d = 32'd0;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q   <= '0;
            irq_out_q    <= 1'b0;
            pending_q    <= '0;
            enable_q     <= '0;
            edge_mode_q  <= '0;
            in_service_q <= '0;
            hist_q       <= '0;
        end else begin
            readdata_q   <= readdata_d;
            irq_out_q    <= irq_out_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            edge_mode_q  <= edge_mode_d;
            in_service_q <= in_service_d;
            hist_q       <= hist_d;
        end
    end

    assign readdata = readdata_q;
    assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_sys_irq_ctrl.sv
// tb/tb_sys_irq_ctrl.sv - directed self-checking bench for sys_irq_ctrl
module tb_sys_irq_ctrl;

`ifdef SYS_IRQ_CTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  irq_src = '0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq_out;

    int checks = 0;
    int errors = 0;

    sys_irq_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_src    (irq_src),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        irq_src    = '0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(1);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        @(posedge clk);
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq_out); end
        for (int a = 0; a < 5; a++) begin
            bus_read(3'(a), d);
            checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", a, d); end
        end
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_read(3'd1, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL enable_width got %h want 000000ff", d); end
        bus_write(3'd5, 32'h0000_00AA);
        bus_read(3'd5, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
        wait_cycles(1);
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL readdata_idle got %h want 0", readdata); end
    endtask

    task automatic test_level();
        logic [31:0] d;
        do_reset();
        bus_write(3'd1, 32'h01);
        irq_src = 8'h01;
        wait_cycles(LAT - 1);
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL level_early got %b want 0", irq_out); end
        wait_cycles(1);
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL level_latency got %b want 1", irq_out); end
        bus_read(3'd2, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL level_claim got %0d want 1", d); end
        wait_cycles(1);
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL level_irq_drop got %b want 0", irq_out); end
        bus_write(3'd2, 32'd1);
        wait_cycles(2);
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL level_repend got %b want 1", irq_out); end
        bus_read(3'd0, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL level_pending got %h want 01", d); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        do_reset();
        bus_write(3'd1, 32'hFF);
        irq_src = 8'h24;
        wait_cycles(LAT + 1);
        bus_read(3'd2, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL prio_claim1 got %0d want 3", d); end
        bus_read(3'd2, d);
        checks++; if (d !== 32'd6) begin errors++; $display("FAIL prio_claim2 got %0d want 6", d); end
        bus_read(3'd2, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL prio_claim3 got %0d want 0", d); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'h24) begin errors++; $display("FAIL prio_inservice got %h want 24", d); end
        bus_read(3'd0, d);
        checks++; if (d !== 32'h00) begin errors++; $display("FAIL prio_pending got %h want 00", d); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL prio_irq got %b want 0", irq_out); end
    endtask

    task automatic test_edge();
        logic [31:0] d;
        do_reset();
        bus_write(3'd3, 32'h08);
        bus_write(3'd1, 32'h08);
        irq_src = 8'h08;
        wait_cycles(1);
        irq_src = 8'h00;
        wait_cycles(LAT + 1);
        bus_read(3'd0, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL edge_pending1 got %h want 08", d); end
        bus_read(3'd2, d);
        checks++; if (d !== 32'd4) begin errors++; $display("FAIL edge_claim got %0d want 4", d); end
        irq_src = 8'h08;
        wait_cycles(1);
        irq_src = 8'h00;
        wait_cycles(LAT + 1);
        bus_read(3'd0, d);
        checks++; if (d !== 32'h08) begin errors++; $display("FAIL edge_pending2 got %h want 08", d); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL edge_irq_in_service got %b want 0", irq_out); end
        bus_write(3'd2, 32'd4);
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL edge_irq_pre got %b want 0", irq_out); end
        wait_cycles(1);
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL edge_irq_post got %b want 1", irq_out); end
    endtask

    task automatic test_complete_ignored();
        logic [31:0] d;
        do_reset();
        bus_write(3'd1, 32'h01);
        irq_src = 8'h41;
        wait_cycles(LAT + 1);
        bus_read(3'd2, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL ign_claim got %0d want 1", d); end
        bus_write(3'd2, 32'd0);
        bus_write(3'd2, 32'd9);
        bus_write(3'd2, 32'd2);
        bus_write(3'd2, 32'd7);
        wait_cycles(1);
        bus_read(3'd4, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL ign_inservice got %h want 01", d); end
        bus_read(3'd0, d);
        checks++; if (d !== 32'h40) begin errors++; $display("FAIL ign_pending got %h want 40", d); end
    endtask

    task automatic test_enable_mask();
        logic [31:0] d;
        do_reset();
        irq_src = 8'h02;
        wait_cycles(LAT + 1);
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mask_irq got %b want 0", irq_out); end
        bus_read(3'd2, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL mask_claim got %0d want 0", d); end
        bus_read(3'd0, d);
        checks++; if (d !== 32'h02) begin errors++; $display("FAIL mask_pending got %h want 02", d); end
        bus_write(3'd1, 32'h02);
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mask_irq_pre got %b want 0", irq_out); end
        wait_cycles(1);
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL mask_irq_post got %b want 1", irq_out); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        do_reset();
        bus_write(3'd1, 32'h03);
        irq_src = 8'h03;
        wait_cycles(LAT + 1);
        bus_read(3'd2, d);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL mid_claim got %0d want 1", d); end
        wait_cycles(2);
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL mid_irq_before got %b want 1", irq_out); end
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 3'd4;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mid_irq_async got %b want 0", irq_out); end
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL mid_rdata_async got %h want 0", readdata); end
        chipselect = 1'b0;
        read_n     = 1'b1;
        irq_src    = 8'h00;
        @(negedge clk);
        wait_cycles(1);
        reset_n = 1'b1;
        wait_cycles(1);
        for (int a = 0; a < 5; a++) begin
            bus_read(3'(a), d);
            checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_reg%0d got %h want 0", a, d); end
        end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mid_irq_after got %b want 0", irq_out); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_priority();
        test_edge();
        test_complete_ignored();
        test_enable_mask();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
